plab1_imul_intmuliterative: RTL
===============================

# plab1_imul_IntMulIterative

Iterative integer multiply responder: the consumer end of the MulDivReq val/rdy stream. Accepts one 67-bit MulDivReq message at a time, computes the low 32 bits of a*b with a shift-add datapath, and returns the product on a 32-bit val/rdy response stream. Sits between the request source/sink harness (or processor) and the multiply/divide functional-unit slot.

## Interface
- No parameters; widths come from the `PLAB1_IMUL_MULDIV_REQ_MSG_*` macros (msg 67b, func 3b, a 32b, b 32b).
- `clk` input 1: single clock; all state updates on rising edge.
- `reset` input 1: synchronous, active-high.
- `req_val` input 1: request valid.
- `req_rdy` output 1: request ready.
- `req_msg` input 67: func[66:64], a[63:32], b[31:0].
- `resp_val` output 1: response valid.
- `resp_rdy` input 1: response ready.
- `resp_msg` output 32: product.

## Operation
- FSM states: IDLE, CALC, DONE.
- IDLE: `req_rdy`=1. On `req_val && req_rdy`: latch a, b into a_reg, b_reg, clear result_reg, clear counter, latch func_is_mul (func == `PLAB1_IMUL_MULDIV_REQ_MSG_FUNC_MUL`); go to CALC.
- CALC, per cycle: if b_reg[0], result_reg += a_reg (mod 2^32); a_reg <<= 1; b_reg >>= 1 (logical); counter++. Leave CALC to DONE after the step where counter reaches 31 (32 steps total).
- CALC with non-MUL func: no steps; result_reg stays 0; go to DONE after one CALC cycle.
- DONE: `resp_val`=1, `resp_msg`=result_reg. On `resp_rdy`, go to IDLE. `resp_msg` stable while `resp_val` high and not accepted.
- `req_rdy`=0 in CALC and DONE; `resp_val`=0 in IDLE and CALC.
- Arithmetic: unsigned shift-add, low 32 bits kept; result identical for signed two's-complement operands.
- Reset (any state, including mid-CALC or DONE with response pending): next state IDLE, in-flight work discarded, `req_rdy`=1, `resp_val`=0, `resp_msg`=0 (result_reg cleared).

## Timing
- Reset values: `req_rdy`=1 (from first post-reset cycle), `resp_val`=0, `resp_msg`=0.
- Accept edge E0. Default: `resp_val` rises after edge E32 (32 edges later); next request accepted no earlier than one edge after the response handshake edge.
- Non-MUL func: `resp_val` rises after E1, `resp_msg`=0.
- No combinational path from `req_val` to `req_rdy`, or `resp_rdy` to `resp_val`; at most one transaction in flight.
- Response backpressure: DONE held indefinitely while `resp_rdy`=0.

## Configuration
- `PLAB1_IMUL_MUL_EARLY_EXIT_EN` defined: in CALC, if b_reg==0 at start of cycle, go to DONE that cycle without a step. Latency in edges from accept to `resp_val` = min(msb_index(b)+2, 32); b=0 gives 1 edge. Product unchanged.
- Undefined: fixed 32-step latency regardless of operands.

## Test plan
- Reset with `req_val`=1 held: `req_rdy`=1, `resp_val`=0, `resp_msg`=0 throughout reset; first accept after reset deasserts.
- Directed MUL: (0x00,0x01)->0x00; (0x42,0x01)->0x42; (0x18,0x68)->0x9C0; (0xFFFFFFFF,0x00000002)->0xFFFFFFFE; (0x80000000,0x80000000)->0x0. Default build: each `resp_val` exactly 32 edges after accept.
- Early-exit build: b=0 -> 1 edge; b=1 -> 2 edges; b=0x68 -> 8 edges; b=0x80000000 -> 32 edges; products as above.
- Backpressure: `resp_rdy`=0 for 5 cycles in DONE -> `resp_val` and `resp_msg` held, `req_rdy`=0; sink random delays 0-7 over 50 random-operand requests -> all products match a*b mod 2^32, in order.
- Non-MUL func (DIV, REMU, each with a=0x42, b=0x01) -> `resp_msg`=0 after 1 edge.
- Reset asserted at CALC step 10 and again in DONE with `resp_rdy`=0 -> IDLE next cycle, no response emitted, following request (0x18,0x68) returns 0x9C0.

Source files
------------

// File: rtl/plab1_imul_intmuliterative.sv
// rtl/plab1_imul_intmuliterative.sv - iterative shift-add 32-bit multiplier on val/rdy streams (option: PLAB1_IMUL_MUL_EARLY_EXIT_EN)

`ifndef PLAB1_IMUL_MULDIV_REQ_MSG_NBITS
`define PLAB1_IMUL_MULDIV_REQ_MSG_NBITS 67
`endif
`ifndef PLAB1_IMUL_MULDIV_REQ_MSG_FUNC_NBITS
`define PLAB1_IMUL_MULDIV_REQ_MSG_FUNC_NBITS 3
`endif
`ifndef PLAB1_IMUL_MULDIV_REQ_MSG_A_NBITS
`define PLAB1_IMUL_MULDIV_REQ_MSG_A_NBITS 32
`endif
`ifndef PLAB1_IMUL_MULDIV_REQ_MSG_B_NBITS
`define PLAB1_IMUL_MULDIV_REQ_MSG_B_NBITS 32
`endif
`ifndef PLAB1_IMUL_MULDIV_REQ_MSG_FUNC_MUL
`define PLAB1_IMUL_MULDIV_REQ_MSG_FUNC_MUL 3'd0
`endif

module plab1_imul_intmuliterative (
  input  logic                                         clk,
  input  logic                                         reset,
  input  logic                                         req_val,
  output logic                                         req_rdy,
  input  logic [`PLAB1_IMUL_MULDIV_REQ_MSG_NBITS-1:0]  req_msg,
  output logic                                         resp_val,
  input  logic                                         resp_rdy,
  output logic [`PLAB1_IMUL_MULDIV_REQ_MSG_A_NBITS-1:0] resp_msg
);

  localparam int AW = `PLAB1_IMUL_MULDIV_REQ_MSG_A_NBITS;
  localparam int BW = `PLAB1_IMUL_MULDIV_REQ_MSG_B_NBITS;
  localparam int FW = `PLAB1_IMUL_MULDIV_REQ_MSG_FUNC_NBITS;

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] CALC = 2'd1;
  localparam logic [1:0] DONE = 2'd2;

  logic [1:0]    state;
  logic [AW-1:0] a_reg;
  logic [BW-1:0] b_reg;
  logic [AW-1:0] result_reg;
  logic [4:0]    counter;
  logic          func_is_mul;

  logic [FW-1:0] req_func;
  logic [AW-1:0] req_a;
  logic [BW-1:0] req_b;

  assign req_func = req_msg[AW+BW+FW-1:AW+BW];
  assign req_a    = req_msg[AW+BW-1:BW];
  assign req_b    = req_msg[BW-1:0];

  // Handshake outputs depend only on state, so there is no combinational
  // path from req_val or resp_rdy.
  assign req_rdy  = (state == IDLE);
  assign resp_val = (state == DONE);
  assign resp_msg = result_reg;

  // Control FSM and shift-add datapath; one partial-product step per CALC cycle.
  always_ff @(posedge clk) begin
    if (reset) begin
      state       <= IDLE;
      a_reg       <= '0;
      b_reg       <= '0;
      result_reg  <= '0;
      counter     <= '0;
      func_is_mul <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (req_val) begin
            a_reg       <= req_a;
            b_reg       <= req_b;
            result_reg  <= '0;
            counter     <= '0;
            func_is_mul <= (req_func == `PLAB1_IMUL_MULDIV_REQ_MSG_FUNC_MUL);
            state       <= CALC;
          end
        end
        CALC: begin
          if (!func_is_mul) begin
            // Only multiply is implemented here; other functions answer zero.
            state <= DONE;
          end
`ifdef PLAB1_IMUL_MUL_EARLY_EXIT_EN
          else if (b_reg == '0) begin
            // No set bits remain in b, so further steps cannot change the result.
            state <= DONE;
          end
`endif
          else begin
            if (b_reg[0]) begin
              result_reg <= result_reg + a_reg;
            end
            a_reg   <= a_reg << 1;
            b_reg   <= b_reg >> 1;
            counter <= counter + 5'd1;
            if (counter == 5'd31) begin
              state <= DONE;
            end
          end
        end
        DONE: begin
          if (resp_rdy) begin
            state <= IDLE;
          end
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule
